// File: rtl/csa_pkg.sv
// Shared helpers for the carry-skip adder family: parameter legality and
// derivation of the number of skip blocks.
package csa_pkg;

  function automatic bit csa_params_ok(input int width, input int block);
    return (block >= 1) && (width >= block) && ((width % block) == 0);
  endfunction

  function automatic int csa_nblk(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/csa_block.sv
// One combinational carry-skip block: ripple sum, group propagate, and a carry-out
// that bypasses the ripple chain when every bit propagates.
module csa_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             prop
);

  logic [BLOCK:0] c;

  always_comb begin
    c[0] = cin;
    sum  = '0;
    for (int i = 0; i < BLOCK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    prop = &(a ^ b);
    cout = prop ? cin : c[BLOCK];
  end

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// Pipelined carry-skip add/subtract: one skip block per stage, valid/ready on both
// sides with full backpressure; results leave in acceptance order.
module pipelined_carry_skip_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  input  logic                    cin,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        sum,
  output logic                    cout,
  output logic                    ovf,
  output logic [WIDTH/BLOCK-1:0]  skip
);

  localparam int NBLK = csa_nblk(WIDTH, BLOCK);

  if (!csa_params_ok(WIDTH, BLOCK)) begin : g_bad_params
    $error("pipelined_carry_skip_adder: WIDTH must be a positive multiple of BLOCK");
  end

  // Operand registers shift right by BLOCK per stage, so each stage always works on
  // bits [BLOCK-1:0]; sum and skip shift in from the top and end up in place.
  logic [WIDTH-1:0] a_q    [NBLK];
  logic [WIDTH-1:0] a_d    [NBLK];
  logic [WIDTH-1:0] b_q    [NBLK];
  logic [WIDTH-1:0] b_d    [NBLK];
  logic [WIDTH-1:0] sum_q  [NBLK];
  logic [WIDTH-1:0] sum_d  [NBLK];
  logic [NBLK-1:0]  skip_q [NBLK];
  logic [NBLK-1:0]  skip_d [NBLK];
  logic [NBLK-1:0]  c_q;
  logic [NBLK-1:0]  c_d;
  logic [NBLK-1:0]  v_q;
  logic [NBLK-1:0]  v_d;
  logic             ovf_q;
  logic             ovf_d;

  logic [WIDTH-1:0] op_a    [NBLK];
  logic [WIDTH-1:0] op_b    [NBLK];
  logic [WIDTH-1:0] sum_in  [NBLK];
  logic [NBLK-1:0]  skip_in [NBLK];
  logic [NBLK-1:0]  c_in;
  logic [NBLK-1:0]  v_in;

  logic [BLOCK-1:0] blk_sum [NBLK];
  logic [NBLK-1:0]  blk_cout;
  logic [NBLK-1:0]  blk_prop;

  logic stall;
  logic accept;

  assign stall  = v_q[NBLK-1] & ~out_ready;
  assign accept = in_valid & ~stall;

  genvar gi;
  for (gi = 0; gi < NBLK; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      // Subtraction folds into addition here: invert B and flip the carry-in.
      assign op_a[gi]    = a;
      assign op_b[gi]    = sub ? ~b : b;
      assign c_in[gi]    = cin ^ sub;
      assign sum_in[gi]  = '0;
      assign skip_in[gi] = '0;
      assign v_in[gi]    = accept;
    end else begin : g_tail
      assign op_a[gi]    = a_q[gi-1];
      assign op_b[gi]    = b_q[gi-1];
      assign c_in[gi]    = c_q[gi-1];
      assign sum_in[gi]  = sum_q[gi-1];
      assign skip_in[gi] = skip_q[gi-1];
      assign v_in[gi]    = v_q[gi-1];
    end

    csa_block #(.BLOCK(BLOCK)) u_blk (
      .a    (op_a[gi][BLOCK-1:0]),
      .b    (op_b[gi][BLOCK-1:0]),
      .cin  (c_in[gi]),
      .sum  (blk_sum[gi]),
      .cout (blk_cout[gi]),
      .prop (blk_prop[gi])
    );
  end

  always_comb begin
    v_d = v_in;
    c_d = blk_cout;
    for (int k = 0; k < NBLK; k++) begin
      a_d[k]    = op_a[k] >> BLOCK;
      b_d[k]    = op_b[k] >> BLOCK;
      sum_d[k]  = (sum_in[k] >> BLOCK) | (WIDTH'(blk_sum[k]) << (WIDTH - BLOCK));
      skip_d[k] = (skip_in[k] >> 1) | (NBLK'(blk_prop[k]) << (NBLK - 1));
    end
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    ovf_d = blk_sum[NBLK-1][BLOCK-1] ^ op_a[NBLK-1][BLOCK-1]
          ^ op_b[NBLK-1][BLOCK-1] ^ blk_cout[NBLK-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NBLK; k++) begin
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        sum_q[k]  <= '0;
        skip_q[k] <= '0;
      end
    end else if (!stall) begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < NBLK; k++) begin
        a_q[k]    <= a_d[k];
        b_q[k]    <= b_d[k];
        sum_q[k]  <= sum_d[k];
        skip_q[k] <= skip_d[k];
      end
    end
  end

  assign in_ready  = ~stall;
  assign out_valid = v_q[NBLK-1];
  assign sum       = sum_q[NBLK-1];
  assign cout      = c_q[NBLK-1];
  assign ovf       = ovf_q;
  assign skip      = skip_q[NBLK-1];

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Self-checking bench: arithmetic reference model plus scoreboard queue, random
// traffic with backpressure, directed vectors, stall and reset scenarios.
module tb_pipelined_carry_skip_adder;

  localparam int W = 16;
  localparam int B = 4;
  localparam int N = W / B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic         cin = 1'b0, sub = 1'b0, cout, ovf;
  logic [W-1:0] a = '0, b = '0, sum;
  logic [N-1:0] skip;

  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
  logic       cin8 = 1'b0, sub8 = 1'b0, cout8, ovf8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic [0:0] skip8;

  pipelined_carry_skip_adder #(.WIDTH(W), .BLOCK(B)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .skip(skip)
  );

  pipelined_carry_skip_adder #(.WIDTH(8), .BLOCK(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .skip(skip8)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [N-1:0] skip;
  } res_t;

  int   passes = 0;
  int   total = 0;
  int   popped = 0;
  bit   rand_or = 1'b0;
  res_t expq[$];
  res_t e_item;
  res_t held;
  bit   held_v = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s);
    int unsigned bb, full;
    res_t r;
    bb     = s ? {16'h0, ~y} : {16'h0, y};
    full   = x + bb + ((ci ^ s) ? 1 : 0);
    r.sum  = full[15:0];
    r.cout = full[16];
    r.ovf  = (x[15] == bb[15]) && (r.sum[15] != x[15]);
    for (int k = 0; k < N; k++)
      r.skip[k] = (((x ^ bb) >> (B * k)) & 32'hF) == 32'hF;
    return r;
  endfunction

  // Scoreboard: records accepts, checks every consumed result and stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      held_v = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (held_v && out_valid) check("stall_stable", {sum, cout, ovf, skip}, held);
      held_v = out_valid && !out_ready;
      held   = {sum, cout, ovf, skip};
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_result", {sum, cout, ovf, skip}, 32'hDEAD_BEEF);
        end else begin
          e_item = expq.pop_front();
          check("result", {sum, cout, ovf, skip}, e_item);
          popped++;
        end
      end
      if (in_valid && in_ready) expq.push_back(model(a, b, cin, sub));
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
    bit acc;
    int n;
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
      n++;
    end while (!acc && n < 200);
    check("send_accepted", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (expq.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_empty", expq.size(), 0);
  endtask

  task automatic run_vec(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic s, input res_t lit);
    int n;
    check({"model_", name}, model(x, y, ci, s), lit);
    send(x, y, ci, s);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({"latency_", name}, n, N - 1);
    check({"dut_", name}, {sum, cout, ovf, skip}, lit);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, p0, n;
    logic [W-1:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_outputs", {sum, cout, ovf, skip}, 0);
    check("rst_out_valid8", out_valid8, 0);
    check("rst_in_ready8", in_ready8, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_vec("carry_into_blk2", 16'h00FF, 16'h0001, 1'b0, 1'b0, res_t'{16'h0100, 1'b0, 1'b0, 4'b0010});
    run_vec("all_skip",        16'hFFFF, 16'h0000, 1'b1, 1'b0, res_t'{16'h0000, 1'b1, 1'b0, 4'b1111});
    run_vec("sub_borrow",      16'h0005, 16'h0007, 1'b0, 1'b1, res_t'{16'hFFFE, 1'b0, 1'b0, 4'b1110});
    run_vec("add_ovf",         16'h7FFF, 16'h0001, 1'b0, 1'b0, res_t'{16'h8000, 1'b0, 1'b1, 4'b0110});
    run_vec("sub_ovf",         16'h8000, 16'h0001, 1'b0, 1'b1, res_t'{16'h7FFF, 1'b1, 1'b1, 4'b0110});

    // Four back-to-back ops, then hold the first result for two cycles.
    out_ready = 1'b1;
    p0 = popped;
    for (int i = 0; i < 4; i++) send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    check("stall_first_valid", out_valid, 1);
    out_ready = 1'b0;
    low = 0;
    repeat (2) begin
      @(negedge clk);
      if (!in_ready) low++;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    if (!in_ready) low++;
    check("stall_in_ready_low", low, 2);
    drain();
    check("stall_results", popped - p0, 4);

    // Random traffic with random backpressure.
    rand_or = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ~ra : W'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
      send(ra, rb, 1'($urandom), 1'($urandom));
    end
    rand_or = 1'b0;
    drain();

    // Reset with ops in flight and the head result stalled at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom), 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("post_rst_idle", out_valid, 0);
    end
    run_vec("after_rst", 16'h1234, 16'h0F0F, 1'b1, 1'b0, res_t'{16'h2144, 1'b0, 1'b0, 4'b0000});

    // Single-block configuration: latency of one edge.
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    check("w8_valid", out_valid8, 1);
    check("w8_result", {sum8, cout8, ovf8, skip8}, {8'h00, 1'b1, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    check("w8_valid_drop", out_valid8, 0);

    check("queue_empty_end", expq.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
